// File: rtl/alu_pwr_seq.sv
// Power sequencer for the ALU input and mux domains: isolate, (save), power off, ramp, (restore).
// Optional retention states are built only when ALU_PWR_SEQ_RETENTION_EN is defined.
module alu_pwr_seq #(
   parameter int ISO_SETUP = 2,
   parameter int OFF_MIN   = 8,
   parameter int RAMP      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_off_req,
   input  logic       mux_off_req,
   output logic       IN_PWR,
   output logic       MUX_PWR,
   output logic [1:0] iso,
   output logic [1:0] ret_save,
   output logic [1:0] ret_restore,
   output logic       busy,
   output logic [2:0] seq_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISO     = 3'd1,
      S_SAVE    = 3'd2,
      S_OFF     = 3'd3,
      S_RAMP    = 3'd4,
      S_RESTORE = 3'd5
   } state_t;

   // Counter is loaded with (cycles - 1) and the state exits when it reaches zero.
   function automatic logic [7:0] load_val(input int n);
      if (n <= 1)
         return 8'd0;
      else if (n > 255)
         return 8'd254;
      else
         return 8'(n - 1);
   endfunction

   localparam logic [7:0] ISO_LD  = load_val(ISO_SETUP);
   localparam logic [7:0] OFF_LD  = load_val(OFF_MIN);
   localparam logic [7:0] RAMP_LD = load_val(RAMP);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       dom_q, dom_d;
   logic [1:0] pwr_q, pwr_d;
   logic [1:0] iso_q, iso_d;
   logic       busy_q, busy_d;
   logic [2:0] seq_state_q, seq_state_d;
   logic [1:0] req;
   logic [1:0] pend;

`ifdef ALU_PWR_SEQ_RETENTION_EN
   logic [1:0] ret_save_q, ret_save_d;
   logic [1:0] ret_restore_q, ret_restore_d;
`endif

   assign req = {mux_off_req, in_off_req};

   // A domain needs work when its request level equals its current supply level.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_pend
         assign pend[gi] = (req[gi] == pwr_q[gi]);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dom_d   = dom_q;
      pwr_d   = pwr_q;
      iso_d   = iso_q;
`ifdef ALU_PWR_SEQ_RETENTION_EN
      ret_save_d    = 2'b00;
      ret_restore_d = 2'b00;
`endif
      case (state_q)
         S_IDLE: begin
            if (pend != 2'b00) begin
               dom_d = ~pend[0];
               if (pwr_q[dom_d]) begin
                  state_d      = S_ISO;
                  iso_d[dom_d] = 1'b1;
                  cnt_d        = ISO_LD;
               end else begin
                  state_d      = S_RAMP;
                  pwr_d[dom_d] = 1'b1;
                  cnt_d        = RAMP_LD;
               end
            end
         end
         S_ISO: begin
            if (cnt_q == 8'd0) begin
`ifdef ALU_PWR_SEQ_RETENTION_EN
               state_d           = S_SAVE;
               ret_save_d[dom_q] = 1'b1;
               cnt_d             = 8'd0;
`else
               state_d      = S_OFF;
               pwr_d[dom_q] = 1'b0;
               cnt_d        = OFF_LD;
`endif
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
`ifdef ALU_PWR_SEQ_RETENTION_EN
         S_SAVE: begin
            state_d      = S_OFF;
            pwr_d[dom_q] = 1'b0;
            cnt_d        = OFF_LD;
         end
`endif
         S_OFF: begin
            if (cnt_q == 8'd0)
               state_d = S_IDLE;
            else
               cnt_d = cnt_q - 8'd1;
         end
         S_RAMP: begin
            if (cnt_q == 8'd0) begin
`ifdef ALU_PWR_SEQ_RETENTION_EN
               state_d              = S_RESTORE;
               ret_restore_d[dom_q] = 1'b1;
               cnt_d                = 8'd0;
`else
               state_d      = S_IDLE;
               iso_d[dom_q] = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
`ifdef ALU_PWR_SEQ_RETENTION_EN
         S_RESTORE: begin
            state_d      = S_IDLE;
            iso_d[dom_q] = 1'b0;
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
      busy_d      = (state_d != S_IDLE);
      seq_state_d = state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         dom_q       <= 1'b0;
         pwr_q       <= 2'b11;
         iso_q       <= 2'b00;
         busy_q      <= 1'b0;
         seq_state_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dom_q       <= dom_d;
         pwr_q       <= pwr_d;
         iso_q       <= iso_d;
         busy_q      <= busy_d;
         seq_state_q <= seq_state_d;
      end
   end

`ifdef ALU_PWR_SEQ_RETENTION_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret_save_q    <= 2'b00;
         ret_restore_q <= 2'b00;
      end else begin
         ret_save_q    <= ret_save_d;
         ret_restore_q <= ret_restore_d;
      end
   end
   assign ret_save    = ret_save_q;
   assign ret_restore = ret_restore_q;
`else
   assign ret_save    = 2'b00;
   assign ret_restore = 2'b00;
`endif

   assign IN_PWR    = pwr_q[0];
   assign MUX_PWR   = pwr_q[1];
   assign iso       = iso_q;
   assign busy      = busy_q;
   assign seq_state = seq_state_q;

endmodule
